bfp_scheduler: RTL and testbench
================================

# bfp_scheduler

Shared, multi-cycle body-fat-percentage engine serving two requesters, each with a valid/ready request port and a valid/ready response port. Round-robin arbitration picks one request and captures weight, height, age and gender. The block then sequences one shared multiplier and one iterative divider to produce BMI and BFP. It sits between the user-input front ends and the display/range logic, replacing the per-gender combinational calculators.

## Interface
- `OFS_FEMALE`, default 540: BFP offset ×100 for female requests.
- `OFS_MALE`, default 1620: BFP offset ×100 for male requests.
- `clk`  in  1  sole clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  request valid; bit i belongs to requester i.
- `req_ready`  out  2  request accepted; at most one bit high.
- `req_weight`  in  16  weight in kg; [8i+7:8i] belongs to requester i.
- `req_height`  in  16  height in cm, packed the same way.
- `req_age`  in  16  age in years, packed the same way.
- `req_female`  in  2  1 = female, 0 = male.
- `rsp_valid`  out  2  one-hot result valid, toward the requester that was served.
- `rsp_ready`  in  2  response accepted by requester i.
- `rsp_bmi`  out  8  BMI, integer, saturated.
- `rsp_bfp`  out  8  BFP in %, integer, clamped to 0..255.
- `rsp_err`  out  1  height was 0; bmi and bfp are forced to 0.

## Operation
- **States:** IDLE, MUL_H, MUL_W, DIV_BMI, MAC, DIV_BFP, RESP.
- **IDLE:** if any `req_valid` bit is high, the round-robin winner gets `req_ready` combinationally in the same cycle. On that edge the winner's fields and id are captured, `last_grant` updates, and the FSM goes to MUL_H.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - Under contention the requesters alternate.
- **MUL_H (1 cycle):** hsq = h*h (16-bit).
- **MUL_W (1 cycle):** num = w*10000 (24-bit; max 2,550,000).
- **DIV_BMI (24 cycles):** restoring division num/hsq.
  - If the quotient exceeds 255, bmi = 255.
  - If h = 0, the division runs but bmi is forced to 0 and err is set.
- **MAC (1 cycle):** signed 18-bit acc = 120*bmi + 23*age − OFS, with OFS selected by the captured gender.
  - If acc < 0, acc = 0.
- **DIV_BFP (16 cycles):** acc/100 with the same divider, truncated.
  - Results above 255 give bfp = 255.
  - If err is set, bfp = 0.
- **RESP:** `rsp_valid` bit for the captured id is high. `rsp_bmi`, `rsp_bfp` and `rsp_err` stay stable until `rsp_ready` for that id; the handshake edge returns the FSM to IDLE.
  - `rsp_ready` on the other bit is ignored.
- **Ownership:** only one request is in flight. `req_ready` is 0 in every state except IDLE.
- **Input changes:** request inputs may change after acceptance with no effect on the result.

## Timing
- **Reset values:** all outputs are 0, state = IDLE, `last_grant` = 1, datapath registers cleared.
- **Reset mid-operation:** an in-flight request is dropped with no response, and the requester must re-issue it.
- **Latency:** `rsp_valid` rises 43 clocks after the accepting edge, the same for every input, including err and clamp cases.
- **Throughput:** the earliest next acceptance is the cycle after the response handshake, so the minimum interval is 45 cycles if `rsp_ready` is held high.
- **Simultaneous events:** a request that asserts in the same cycle as a response handshake is not seen until IDLE.
- **Request hold:** `req_valid` deasserting before its `req_ready` is allowed; that request is simply not served.

## Structure
- Package `bfp_pkg` holds:
  - the state enum;
  - the constants 10000, 120, 23 and 100;
  - the divider widths 24/16/17;
  - the latency constant 43.
- Sub-module `seq_divider`: restoring, unsigned, with parameterized dividend and divisor widths and an iteration count. It has start/done handshake signals and one quotient bit per cycle. It is instantiated once and time-shared by DIV_BMI and DIV_BFP, with a runtime iteration count.
- The multiplier is a single shared combinational `*`, with its operands muxed by state.

## Test plan
- **Basic female request:** req0 w=70, h=175, age=30, female → after 43 cycles bmi=22, bfp=27, err=0, rsp_valid=2'b01.
- **Basic male request:** req1 same fields, male → bmi=22, bfp=17, rsp_valid=2'b10.
- **Saturation:** w=200, h=100, age=90, female → bmi=200, bfp=255. In a separate check, w=255, h=10 → bmi=255.
- **Negative clamp and err:**
  - w=20, h=200, age=0, male → bmi=5, bfp=0.
  - h=0 → err=1, bmi=0, bfp=0, latency still 43.
- **Contention:** both `req_valid` held high with `rsp_ready` high → grants alternate 0,1,0,1 and each response is routed to the right requester. Holding `rsp_ready`=0 for 10 cycles keeps the outputs stable and delays the next grant.
- **Reset mid-operation:** `nrst` low at cycle 20 of DIV_BMI → all outputs are 0 immediately. After release, the next grant goes to requester 0.

Source files
------------

// File: rtl/bfp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bfp_pkg
// Brief    : Shared types and constants for the BMI/BFP scheduler.
// Revision : 1.0
// ============================================================================
package bfp_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL_H   = 3'd1,
        S_MUL_W   = 3'd2,
        S_DIV_BMI = 3'd3,
        S_MAC     = 3'd4,
        S_DIV_BFP = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    localparam logic [15:0] c_W_SCALE   = 16'd10000;
    localparam logic [15:0] c_BMI_K     = 16'd120;
    localparam logic [15:0] c_AGE_K     = 16'd23;
    localparam logic [15:0] c_PCT       = 16'd100;

    localparam int          c_DVD_W     = 24;
    localparam int          c_DVS_W     = 16;
    localparam int          c_REM_W     = 17;
    localparam int          c_CNT_W     = 5;
    localparam logic [4:0]  c_BMI_ITERS = 5'd24;
    localparam logic [4:0]  c_BFP_ITERS = 5'd16;

    localparam int          c_LATENCY   = 43;

    function automatic logic [7:0] sat8(input logic [23:0] v);
        return (v > 24'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : bfp_scheduler_if
// Brief    : Two-requester request/response bundle for the BFP scheduler.
// Revision : 1.0
// ============================================================================
interface bfp_scheduler_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_weight;
    logic [15:0] req_height;
    logic [15:0] req_age;
    logic [1:0]  req_female;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_bmi;
    logic [7:0]  rsp_bfp;
    logic        rsp_err;

    modport master (
        output req_valid, req_weight, req_height, req_age, req_female, rsp_ready,
        input  req_ready, rsp_valid, rsp_bmi, rsp_bfp, rsp_err
    );

    modport slave (
        input  req_valid, req_weight, req_height, req_age, req_female, rsp_ready,
        output req_ready, rsp_valid, rsp_bmi, rsp_bfp, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/bfp_scheduler_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Restoring unsigned divider, one quotient bit per cycle, MSB first.
// Revision : 1.0
// ============================================================================
module seq_divider #(
    parameter int DVD_W = 24,
    parameter int DVS_W = 16,
    parameter int REM_W = DVS_W + 1,
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             nrst,
    input  wire logic             i_start,
    input  wire logic [CNT_W-1:0] i_iters,
    input  wire logic [DVD_W-1:0] i_dividend,
    input  wire logic [DVS_W-1:0] i_divisor,
    output logic                  o_done,
    output logic      [DVD_W-1:0] o_quotient
);
    logic [DVD_W-1:0] r_quo;
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic [REM_W-1:0] w_shift;
    logic [REM_W-1:0] w_diff;
    logic             w_bit;

    assign w_shift = {r_rem, r_quo[DVD_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_bit   = (w_shift >= {1'b0, r_dvs});

    // Short divisions are left-aligned by the caller, so the low quotient bits come out clean.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
            r_cnt <= i_iters;
        end else if (r_cnt != '0) begin
            r_quo <= {r_quo[DVD_W-2:0], w_bit};
            r_rem <= w_bit ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done     = (r_cnt == CNT_W'(1));
    assign o_quotient = r_quo;
endmodule
`default_nettype wire

// File: rtl/bfp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bfp_scheduler
// Brief    : Round-robin, time-shared BMI/BFP engine for two requesters.
// Revision : 1.0
// ============================================================================
module bfp_scheduler #(
    parameter int OFS_FEMALE = 540,
    parameter int OFS_MALE   = 1620
) (
    input  wire logic       clk,
    input  wire logic       nrst,
    bfp_scheduler_if.slave  bus
);
    import bfp_pkg::*;

    state_t      r_state, w_next;
    logic        r_last, r_id, r_female, r_err;
    logic [7:0]  r_w, r_h, r_age, r_bmi;
    logic [15:0] r_hsq, r_age23;

    logic        w_win, w_accept;
    logic [1:0]  w_grant;
    logic [7:0]  w_h_sel;
    logic [7:0]  w_mul_a;
    logic [15:0] w_mul_b;
    logic [23:0] w_prod;
    logic [15:0] w_ofs;
    logic [17:0] w_acc;
    logic [15:0] w_acc_pos;
    logic [7:0]  w_bmi;
    logic        w_div_start, w_div_done;
    logic [4:0]  w_div_iters;
    logic [23:0] w_div_dvd, w_div_quo;
    logic [15:0] w_div_dvs;

    // Under contention the requester not granted last time wins.
    assign w_win    = (bus.req_valid == 2'b11) ? ~r_last : bus.req_valid[1];
    assign w_grant  = (r_state == S_IDLE && nrst) ? ((w_win ? 2'b10 : 2'b01) & bus.req_valid) : 2'b00;
    assign w_accept = |w_grant;
    assign w_h_sel  = w_win ? bus.req_height[15:8] : bus.req_height[7:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_MUL_H;
            S_MUL_H:   w_next = S_MUL_W;
            S_MUL_W:   w_next = S_DIV_BMI;
            S_DIV_BMI: if (w_div_done) w_next = S_MAC;
            S_MAC:     w_next = S_DIV_BFP;
            S_DIV_BFP: if (w_div_done) w_next = S_RESP;
            S_RESP:    if (bus.rsp_ready[r_id]) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = w_grant;
        bus.rsp_valid = 2'b00;
        bus.rsp_bmi   = 8'd0;
        bus.rsp_bfp   = 8'd0;
        bus.rsp_err   = 1'b0;
        if (r_state == S_RESP) begin
            bus.rsp_valid = r_id ? 2'b10 : 2'b01;
            bus.rsp_bmi   = r_bmi;
            bus.rsp_bfp   = r_err ? 8'd0 : sat8(w_div_quo);
            bus.rsp_err   = r_err;
        end
    end

    // The multiplier is idle during DIV_BMI, so 23*age is precomputed there.
    always_comb begin
        w_mul_a = 8'd0;
        w_mul_b = 16'd0;
        case (r_state)
            S_MUL_H:   begin w_mul_a = r_h;   w_mul_b = {8'd0, r_h}; end
            S_MUL_W:   begin w_mul_a = r_w;   w_mul_b = c_W_SCALE;   end
            S_DIV_BMI: begin w_mul_a = r_age; w_mul_b = c_AGE_K;     end
            S_MAC:     begin w_mul_a = w_bmi; w_mul_b = c_BMI_K;     end
            default:   ;
        endcase
    end

    assign w_prod    = {16'd0, w_mul_a} * {8'd0, w_mul_b};
    assign w_bmi     = r_err ? 8'd0 : sat8(w_div_quo);
    assign w_ofs     = r_female ? 16'(OFS_FEMALE) : 16'(OFS_MALE);
    assign w_acc     = {2'b00, w_prod[15:0]} + {2'b00, r_age23} - {2'b00, w_ofs};
    assign w_acc_pos = w_acc[17] ? 16'd0 : (w_acc[16] ? 16'hFFFF : w_acc[15:0]);

    assign w_div_start = (r_state == S_MUL_W) || (r_state == S_MAC);
    assign w_div_iters = (r_state == S_MUL_W) ? c_BMI_ITERS : c_BFP_ITERS;
    assign w_div_dvd   = (r_state == S_MUL_W) ? w_prod : {w_acc_pos, 8'h00};
    assign w_div_dvs   = (r_state == S_MUL_W) ? r_hsq : c_PCT;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_female <= 1'b0;
            r_err    <= 1'b0;
            r_w      <= 8'd0;
            r_h      <= 8'd0;
            r_age    <= 8'd0;
            r_bmi    <= 8'd0;
            r_hsq    <= 16'd0;
            r_age23  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_id     <= w_win;
                r_last   <= w_win;
                r_w      <= w_win ? bus.req_weight[15:8] : bus.req_weight[7:0];
                r_h      <= w_h_sel;
                r_age    <= w_win ? bus.req_age[15:8] : bus.req_age[7:0];
                r_female <= bus.req_female[w_win];
                r_err    <= (w_h_sel == 8'd0);
            end
            if (r_state == S_MUL_H)   r_hsq   <= w_prod[15:0];
            if (r_state == S_DIV_BMI) r_age23 <= w_prod[15:0];
            if (r_state == S_MAC)     r_bmi   <= w_bmi;
        end
    end

    seq_divider #(
        .DVD_W (c_DVD_W),
        .DVS_W (c_DVS_W),
        .REM_W (c_REM_W),
        .CNT_W (c_CNT_W)
    ) u_div (
        .clk        (clk),
        .nrst       (nrst),
        .i_start    (w_div_start),
        .i_iters    (w_div_iters),
        .i_dividend (w_div_dvd),
        .i_divisor  (w_div_dvs),
        .o_done     (w_div_done),
        .o_quotient (w_div_quo)
    );
endmodule
`default_nettype wire

// File: tb/tb_bfp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfp_scheduler
// Brief    : Self-checking bench for bfp_scheduler against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_bfp_scheduler;
    import bfp_pkg::*;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    bfp_scheduler_if bus();

    bfp_scheduler #(.OFS_FEMALE(540), .OFS_MALE(1620)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    function automatic void model(input int w, input int h, input int age, input bit fem,
                                  output int bmi, output int bfp, output bit err);
        int acc;
        if (h == 0) begin
            err = 1'b1; bmi = 0; bfp = 0;
            return;
        end
        err = 1'b0;
        bmi = (w * 10000) / (h * h);
        if (bmi > 255) bmi = 255;
        acc = 120 * bmi + 23 * age - (fem ? 540 : 1620);
        if (acc < 0) acc = 0;
        bfp = acc / 100;
        if (bfp > 255) bfp = 255;
    endfunction

    task automatic set_fields(input int id, input int w, input int h, input int age, input bit fem);
        bus.req_weight[id*8 +: 8] = 8'(w);
        bus.req_height[id*8 +: 8] = 8'(h);
        bus.req_age[id*8 +: 8]    = 8'(age);
        bus.req_female[id]        = fem;
    endtask

    task automatic run_one(input int id, input int w, input int h, input int age,
                           input bit fem, input int stall);
        int         e_bmi, e_bfp, cnt;
        bit         e_err, stable;
        logic [1:0] oh;
        model(w, h, age, fem, e_bmi, e_bfp, e_err);
        oh = (id == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        set_fields(id, w, h, age, fem);
        bus.req_valid = oh;
        #1 check("req_ready", bus.req_ready, oh);
        @(posedge clk);
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (cnt == 0) begin
                check("ready_busy", bus.req_ready, 2'b00);
                bus.req_valid  = 2'b00;
                bus.req_weight = 16'($urandom);
                bus.req_height = 16'($urandom);
                bus.req_age    = 16'($urandom);
                bus.req_female = 2'($urandom);
            end
            if (bus.rsp_valid != 2'b00) break;
            @(posedge clk);
            cnt++;
        end
        check("latency", cnt, c_LATENCY);
        check("rsp_valid", bus.rsp_valid, oh);
        check("rsp_bmi", bus.rsp_bmi, e_bmi);
        check("rsp_bfp", bus.rsp_bfp, e_bfp);
        check("rsp_err", bus.rsp_err, e_err);
        if (stall > 0) begin
            bus.rsp_ready = ~oh;
            bus.req_valid = ~oh;
            stable = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                #1;
                if (bus.rsp_valid !== oh || bus.rsp_bmi !== 8'(e_bmi) || bus.rsp_bfp !== 8'(e_bfp) ||
                    bus.rsp_err !== e_err || bus.req_ready !== 2'b00)
                    stable = 1'b0;
            end
            check("stall_stable", stable, 1);
        end
        bus.rsp_ready = oh;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b00;
        #1 check("rsp_done", bus.rsp_valid, 2'b00);
    endtask

    initial begin
        int  fw[2], fh[2], fa[2];
        bit  ff[2];
        int  e_bmi, e_bfp, cnt, gid;
        bit  e_err, quiet;

        bus.req_valid  = 2'b00;
        bus.req_weight = 16'd0;
        bus.req_height = 16'd0;
        bus.req_age    = 16'd0;
        bus.req_female = 2'b00;
        bus.rsp_ready  = 2'b00;

        repeat (3) @(negedge clk);
        bus.req_valid = 2'b11;
        #1 check("reset_outputs",
                 {bus.req_ready, bus.rsp_valid, bus.rsp_bmi, bus.rsp_bfp, bus.rsp_err}, 0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        nrst = 1'b1;

        run_one(0, 70, 175, 30, 1'b1, 0);
        run_one(1, 70, 175, 30, 1'b0, 10);
        run_one(0, 200, 100, 90, 1'b1, 0);
        run_one(1, 255, 10, 40, 1'b0, 0);
        run_one(0, 20, 200, 0, 1'b0, 2);
        run_one(1, 90, 0, 50, 1'b1, 0);

        for (int i = 0; i < 10; i++) begin
            run_one(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)),
                    int'($urandom_range(0, 120)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
        end

        // Requester 0 takes the last grant, then is reset mid-division.
        @(negedge clk);
        set_fields(0, 70, 175, 30, 1'b1);
        bus.req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (21) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b11;
        nrst = 1'b0;
        #1 check("reset_mid",
                 {bus.req_ready, bus.rsp_valid, bus.rsp_bmi, bus.rsp_bfp, bus.rsp_err}, 0);
        repeat (2) @(negedge clk);
        bus.req_valid = 2'b00;
        nrst = 1'b1;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) quiet = 1'b0;
        end
        check("dropped_no_rsp", quiet, 1);

        for (int r = 0; r < 2; r++) begin
            fw[r] = int'($urandom_range(0, 255));
            fh[r] = int'($urandom_range(1, 255));
            fa[r] = int'($urandom_range(0, 120));
            ff[r] = 1'($urandom_range(0, 1));
            set_fields(r, fw[r], fh[r], fa[r], ff[r]);
        end
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            gid = t % 2;
            cnt = 0;
            while (bus.req_ready == 2'b00 && cnt < 100) begin
                @(posedge clk);
                @(negedge clk);
                cnt++;
            end
            check("grant", bus.req_ready, (gid == 1) ? 2'b10 : 2'b01);
            check("grant_gap", cnt, 0);
            model(fw[gid], fh[gid], fa[gid], ff[gid], e_bmi, e_bfp, e_err);
            @(posedge clk);
            cnt = 0;
            while (cnt < 100) begin
                @(negedge clk);
                if (bus.rsp_valid != 2'b00) break;
                @(posedge clk);
                cnt++;
            end
            check("cont_latency", cnt, c_LATENCY);
            check("cont_route", bus.rsp_valid, (gid == 1) ? 2'b10 : 2'b01);
            check("cont_bmi", bus.rsp_bmi, e_bmi);
            check("cont_bfp", bus.rsp_bfp, e_bfp);
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
